// File: rtl/arch_map_table_pkg.sv
// Shared types and constants for the retirement-side architectural map.
// Holds the default geometry, the retire and free packet records and the
// copy-out FSM state encoding.
package arch_map_table_pkg;

  // Physical tags travel on the CDB, so the map tag width tracks it.
  localparam int unsigned CDB_TAG_BITS  = 6;
  localparam int unsigned MAP_PTAG_BITS = CDB_TAG_BITS;

  localparam int unsigned MAP_ARCH_REGS = 32;
  localparam int unsigned MAP_AREG_BITS = $clog2(MAP_ARCH_REGS);
  localparam int unsigned MAP_N_WAY     = 2;
  localparam int unsigned MAP_COPY_W    = 8;

  // One retire slot: commit ptag into areg when valid.
  typedef struct packed {
    logic                     valid;
    logic [MAP_AREG_BITS-1:0] areg;
    logic [MAP_PTAG_BITS-1:0] ptag;
  } retire_map_packet_t;

  // One released tag headed for the free list.
  typedef struct packed {
    logic                     valid;
    logic [MAP_PTAG_BITS-1:0] ptag;
  } free_tag_packet_t;

  typedef enum logic [0:0] {
    MapIdle,
    MapCopy
  } map_state_e;

  // A single-beat copy still needs a one-bit counter.
  function automatic int unsigned beat_cnt_bits(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/arch_map_table_retire_commit_chain.sv
// Combinational retire chain. Walks the retire slots oldest-first over a
// working copy of the map so that each slot sees the writes of the older
// slots in the same cycle.
//   slots_i     : per-slot retire records (valid already qualified)
//   map_i       : current committed map
//   map_we_o    : per-entry write enable for the next map
//   map_wdata_o : per-entry write data (youngest writer wins)
//   free_o      : per-slot displaced tag; valid dropped on a self-remap
module arch_map_table_retire_commit_chain
  import arch_map_table_pkg::*;
#(
  parameter int unsigned ARCH_REGS = MAP_ARCH_REGS,
  parameter int unsigned PTAG_BITS = MAP_PTAG_BITS,
  parameter int unsigned N_WAY     = MAP_N_WAY
) (
  input  retire_map_packet_t [N_WAY-1:0]                 slots_i,
  input  logic               [ARCH_REGS-1:0][PTAG_BITS-1:0] map_i,
  output logic               [ARCH_REGS-1:0]                map_we_o,
  output logic               [ARCH_REGS-1:0][PTAG_BITS-1:0] map_wdata_o,
  output free_tag_packet_t   [N_WAY-1:0]                 free_o
);

  logic [ARCH_REGS-1:0][PTAG_BITS-1:0] walk;

  always_comb begin
    walk     = map_i;
    map_we_o = '0;
    free_o   = '0;
    for (int k = 0; k < N_WAY; k++) begin
      if (slots_i[k].valid) begin
        // Displaced tag is whatever the older slots left behind.
        free_o[k].ptag  = walk[slots_i[k].areg];
        free_o[k].valid = (walk[slots_i[k].areg] != slots_i[k].ptag);
        walk[slots_i[k].areg]     = slots_i[k].ptag;
        map_we_o[slots_i[k].areg] = 1'b1;
      end
    end
    map_wdata_o = walk;
  end

endmodule

// File: rtl/arch_map_table.sv
// Retirement-side architectural register map.
// Commits retiring tags into the map, releases displaced tags one cycle later
// and, on recover_req, streams the committed map to the rename table in beats.
//   clock, reset          : clock, synchronous active-high reset
//   ret_valid/areg/ptag   : retire slots, slot 0 oldest
//   ret_ready             : retirements accepted (IDLE only)
//   free_valid/free_ptag  : registered displaced tags
//   recover_req           : pulse starting a map copy-out
//   copy_valid/base/ptag  : one copy beat of COPY_W entries
//   copy_done             : marks the last beat
//   busy                  : copy-out in progress
module arch_map_table
  import arch_map_table_pkg::*;
#(
  parameter  int unsigned ARCH_REGS = MAP_ARCH_REGS,
  parameter  int unsigned PTAG_BITS = MAP_PTAG_BITS,
  parameter  int unsigned N_WAY     = MAP_N_WAY,
  parameter  int unsigned COPY_W    = MAP_COPY_W,
  localparam int unsigned AREG_BITS = $clog2(ARCH_REGS)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [N_WAY-1:0]                    ret_valid,
  input  logic [N_WAY-1:0][AREG_BITS-1:0]     ret_areg,
  input  logic [N_WAY-1:0][PTAG_BITS-1:0]     ret_ptag,
  output logic                                ret_ready,
  output logic [N_WAY-1:0]                    free_valid,
  output logic [N_WAY-1:0][PTAG_BITS-1:0]     free_ptag,
  input  logic                                recover_req,
  output logic                                copy_valid,
  output logic [AREG_BITS-1:0]                copy_base,
  output logic [COPY_W-1:0][PTAG_BITS-1:0]    copy_ptag,
  output logic                                copy_done,
  output logic                                busy
);

  localparam int unsigned BEATS    = ARCH_REGS / COPY_W;
  localparam int unsigned CNT_BITS = beat_cnt_bits(BEATS);
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

  map_state_e state_q, state_d;
  logic [CNT_BITS-1:0] beat_q, beat_d;
  logic [AREG_BITS-1:0] next_base;

  logic [ARCH_REGS-1:0][PTAG_BITS-1:0] map_q, map_d, map_wdata;
  logic [ARCH_REGS-1:0]                map_we;
  logic [COPY_W-1:0][PTAG_BITS-1:0]    copy_ptag_q, copy_ptag_d;

  retire_map_packet_t [N_WAY-1:0] slots;
  free_tag_packet_t   [N_WAY-1:0] free_q, free_d;

  // Slots offered while copying are dropped here, before touching the map.
  always_comb begin
    slots = '0;
    for (int k = 0; k < N_WAY; k++) begin
      slots[k].valid = ret_valid[k] & ret_ready;
      slots[k].areg  = ret_areg[k];
      slots[k].ptag  = ret_ptag[k];
    end
  end

  arch_map_table_retire_commit_chain #(
    .ARCH_REGS (ARCH_REGS),
    .PTAG_BITS (PTAG_BITS),
    .N_WAY     (N_WAY)
  ) u_chain (
    .slots_i     (slots),
    .map_i       (map_q),
    .map_we_o    (map_we),
    .map_wdata_o (map_wdata),
    .free_o      (free_d)
  );

  always_comb begin
    map_d = map_q;
    for (int i = 0; i < ARCH_REGS; i++) begin
      if (map_we[i]) map_d[i] = map_wdata[i];
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= MapIdle;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MapIdle: if (recover_req) state_d = MapCopy;
      MapCopy: if (beat_q == LAST_BEAT) state_d = MapIdle;
      default: state_d = MapIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    ret_ready  = (state_q == MapIdle);
    busy       = (state_q == MapCopy);
    copy_valid = (state_q == MapCopy);
    copy_done  = (state_q == MapCopy) && (beat_q == LAST_BEAT);
    copy_base  = AREG_BITS'(32'(beat_q) * COPY_W);
  end

  // Beat counter and copy data. The copy register loads from map_d so the
  // first beat already reflects retirements accepted alongside recover_req.
  always_comb begin
    beat_d = '0;
    if ((state_q == MapCopy) && (beat_q != LAST_BEAT)) beat_d = beat_q + 1'b1;
    next_base   = AREG_BITS'(32'(beat_d) * COPY_W);
    copy_ptag_d = '0;
    if (state_d == MapCopy) begin
      for (int j = 0; j < COPY_W; j++) begin
        copy_ptag_d[j] = map_d[next_base + AREG_BITS'(j)];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PTAG_BITS'(i + 1);
      beat_q      <= '0;
      copy_ptag_q <= '0;
      free_q      <= '0;
    end else begin
      map_q       <= map_d;
      beat_q      <= beat_d;
      copy_ptag_q <= copy_ptag_d;
      free_q      <= free_d;
    end
  end

  always_comb begin
    for (int k = 0; k < N_WAY; k++) begin
      free_valid[k] = free_q[k].valid;
      free_ptag[k]  = free_q[k].ptag;
    end
    copy_ptag = copy_ptag_q;
  end

endmodule

// File: tb/tb_arch_map_table.sv
module tb_arch_map_table;
  localparam int ARCH_REGS = 32;
  localparam int PTAG_BITS = 6;
  localparam int N_WAY     = 2;
  localparam int COPY_W    = 8;
  localparam int AREG_BITS = 5;
  localparam int BEATS     = ARCH_REGS / COPY_W;

  logic                            clock = 1'b0;
  logic                            reset;
  logic [N_WAY-1:0]                ret_valid;
  logic [N_WAY-1:0][AREG_BITS-1:0] ret_areg;
  logic [N_WAY-1:0][PTAG_BITS-1:0] ret_ptag;
  logic                            ret_ready;
  logic [N_WAY-1:0]                free_valid;
  logic [N_WAY-1:0][PTAG_BITS-1:0] free_ptag;
  logic                            recover_req;
  logic                            copy_valid;
  logic [AREG_BITS-1:0]            copy_base;
  logic [COPY_W-1:0][PTAG_BITS-1:0] copy_ptag;
  logic                            copy_done;
  logic                            busy;

  arch_map_table dut (
    .clock       (clock),
    .reset       (reset),
    .ret_valid   (ret_valid),
    .ret_areg    (ret_areg),
    .ret_ptag    (ret_ptag),
    .ret_ready   (ret_ready),
    .free_valid  (free_valid),
    .free_ptag   (free_ptag),
    .recover_req (recover_req),
    .copy_valid  (copy_valid),
    .copy_base   (copy_base),
    .copy_ptag   (copy_ptag),
    .copy_done   (copy_done),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    ret_valid   = '0;
    ret_areg    = '0;
    ret_ptag    = '0;
    recover_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Pulse recover_req and check all beats against an expected 32-entry map.
  task automatic check_copy(input string tag, input int exp_map[ARCH_REGS]);
    recover_req = 1'b1;
    tick();
    recover_req = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      chk({tag, "_valid"}, copy_valid, 1);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_ready"}, ret_ready, 0);
      chk({tag, "_base"}, copy_base, b * COPY_W);
      chk({tag, "_done"}, copy_done, (b == BEATS - 1));
      for (int j = 0; j < COPY_W; j++)
        chk({tag, "_ptag"}, copy_ptag[j], exp_map[b * COPY_W + j]);
      tick();
    end
    chk({tag, "_end_valid"}, copy_valid, 0);
    chk({tag, "_end_busy"}, busy, 0);
    chk({tag, "_end_ready"}, ret_ready, 1);
  endtask

  typedef struct {
    logic [1:0] valid;
    int         areg0, ptag0, areg1, ptag1;
    logic [1:0] exp_fv;
    int         exp_fp0, exp_fp1;
  } vec_t;

  vec_t vecs[6];
  int   ident[ARCH_REGS];
  int   expm[ARCH_REGS];

  // Reference model state for the random phase.
  int   m_map[ARCH_REGS];
  bit   m_copy;
  int   m_beat;
  logic [1:0] m_fv;
  int   m_fp[N_WAY];

  initial begin
    // After reset, each single-cycle commit yields these frees one cycle later.
    vecs[0] = '{2'b01, 5, 40, 0, 0, 2'b01, 6, 0};   // plain commit
    vecs[1] = '{2'b11, 3, 41, 3, 42, 2'b11, 4, 41}; // same areg in both slots
    vecs[2] = '{2'b01, 7, 8, 0, 0, 2'b00, 0, 0};    // self-remap
    vecs[3] = '{2'b10, 0, 0, 5, 45, 2'b10, 0, 40};  // slot 1 only
    vecs[4] = '{2'b00, 1, 9, 2, 9, 2'b00, 0, 0};    // nothing valid
    vecs[5] = '{2'b11, 31, 60, 0, 61, 2'b11, 32, 1};
    for (int i = 0; i < ARCH_REGS; i++) ident[i] = i + 1;

    clear_inputs();
    do_reset();
    chk("rst_ready", ret_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_copy_valid", copy_valid, 0);
    chk("rst_copy_done", copy_done, 0);
    chk("rst_copy_base", copy_base, 0);
    chk("rst_copy_ptag", copy_ptag, 0);
    chk("rst_free_valid", free_valid, 0);
    chk("rst_free_ptag", free_ptag, 0);

    check_copy("rst_copy", ident);

    for (int v = 0; v < 6; v++) begin
      ret_valid   = vecs[v].valid;
      ret_areg[0] = AREG_BITS'(vecs[v].areg0);
      ret_ptag[0] = PTAG_BITS'(vecs[v].ptag0);
      ret_areg[1] = AREG_BITS'(vecs[v].areg1);
      ret_ptag[1] = PTAG_BITS'(vecs[v].ptag1);
      chk("tbl_ready", ret_ready, 1);
      tick();
      clear_inputs();
      chk("tbl_free_valid", free_valid, vecs[v].exp_fv);
      if (vecs[v].exp_fv[0]) chk("tbl_free_ptag0", free_ptag[0], vecs[v].exp_fp0);
      if (vecs[v].exp_fv[1]) chk("tbl_free_ptag1", free_ptag[1], vecs[v].exp_fp1);
    end

    // Recovery together with a commit: the copy must see the commit.
    for (int i = 0; i < ARCH_REGS; i++) expm[i] = i + 1;
    expm[0] = 50; expm[3] = 42; expm[5] = 45; expm[31] = 60;
    ret_valid   = 2'b01;
    ret_areg[0] = 5'd0;
    ret_ptag[0] = 6'd50;
    recover_req = 1'b1;
    tick();
    clear_inputs();
    chk("rc_free_valid", free_valid, 2'b01);
    chk("rc_free_ptag0", free_ptag[0], 61);
    for (int b = 0; b < BEATS; b++) begin
      chk("rc_valid", copy_valid, 1);
      chk("rc_base", copy_base, b * COPY_W);
      chk("rc_done", copy_done, (b == BEATS - 1));
      for (int j = 0; j < COPY_W; j++) chk("rc_ptag", copy_ptag[j], expm[b * COPY_W + j]);
      chk("rc_ready", ret_ready, 0);
      // Retire attempts while copying must be ignored.
      ret_valid   = 2'b11;
      ret_areg[0] = 5'd1;
      ret_ptag[0] = 6'd55;
      ret_areg[1] = 5'd2;
      ret_ptag[1] = 6'd56;
      tick();
      clear_inputs();
      chk("rc_ignored_free", free_valid, 0);
    end
    chk("rc_end_ready", ret_ready, 1);
    check_copy("rc_again", expm);

    // Reset on the second beat aborts the copy and restores the map.
    recover_req = 1'b1;
    tick();
    recover_req = 1'b0;
    tick();
    chk("ab_beat1_base", copy_base, COPY_W);
    reset = 1'b1;
    tick();
    chk("ab_copy_valid", copy_valid, 0);
    chk("ab_busy", busy, 0);
    chk("ab_ready", ret_ready, 1);
    reset = 1'b0;
    tick();
    chk("ab_still_idle", copy_valid, 0);
    check_copy("ab_map", ident);

    // Random phase against the reference model.
    do_reset();
    for (int i = 0; i < ARCH_REGS; i++) m_map[i] = i + 1;
    m_copy = 0;
    m_beat = 0;
    for (int c = 0; c < 400; c++) begin
      bit rst;
      rst         = ($urandom_range(0, 63) == 0);
      reset       = rst;
      ret_valid   = N_WAY'($urandom_range(0, 3));
      recover_req = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < N_WAY; k++) begin
        ret_areg[k] = AREG_BITS'($urandom_range(0, ARCH_REGS - 1));
        ret_ptag[k] = PTAG_BITS'($urandom_range(1, 63));
      end
      chk("rnd_ready", ret_ready, !m_copy);
      tick();

      m_fv = '0;
      for (int k = 0; k < N_WAY; k++) m_fp[k] = 0;
      if (rst) begin
        for (int i = 0; i < ARCH_REGS; i++) m_map[i] = i + 1;
        m_copy = 0;
        m_beat = 0;
      end else begin
        if (!m_copy) begin
          for (int k = 0; k < N_WAY; k++) begin
            if (ret_valid[k]) begin
              int a;
              a = int'(ret_areg[k]);
              m_fp[k] = m_map[a];
              m_fv[k] = (m_map[a] != int'(ret_ptag[k]));
              m_map[a] = int'(ret_ptag[k]);
            end
          end
        end
        if (m_copy) begin
          if (m_beat == BEATS - 1) begin
            m_copy = 0;
            m_beat = 0;
          end else begin
            m_beat++;
          end
        end else if (recover_req) begin
          m_copy = 1;
          m_beat = 0;
        end
      end
      reset = 1'b0;

      chk("rnd_free_valid", free_valid, m_fv);
      for (int k = 0; k < N_WAY; k++)
        if (m_fv[k] || rst) chk("rnd_free_ptag", free_ptag[k], m_fp[k]);
      chk("rnd_copy_valid", copy_valid, m_copy);
      chk("rnd_busy", busy, m_copy);
      chk("rnd_copy_done", copy_done, m_copy && (m_beat == BEATS - 1));
      if (m_copy) begin
        chk("rnd_copy_base", copy_base, m_beat * COPY_W);
        for (int j = 0; j < COPY_W; j++)
          chk("rnd_copy_ptag", copy_ptag[j], m_map[m_beat * COPY_W + j]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
